// File: rtl/div_seq.sv
// Iterative restoring divider (1 quotient bit/cycle) with pipeline stall for DIV/DIVU.
// Define DIV_ANNUL_EN to let 'annul' cancel an op in flight; otherwise 'annul' is ignored.
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             annul,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             stall,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    stateT            state, stateNext;
    logic [CW-1:0]    cnt, cntNext;
    logic [WIDTH-1:0] remR, remNext;
    logic [WIDTH-1:0] dvd, dvdNext;
    logic [WIDTH-1:0] dvs, dvsNext;
    logic             negQ, negQNext, negR, negRNext;
    logic             busyNext, readyNext, dbzNext;
    logic [WIDTH-1:0] quotientNext, remainderNext;

    logic             startAcc, annulCalc;
    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH-1:0] stepRem, stepQ, absA, absB;

`ifdef DIV_ANNUL_EN
    assign startAcc  = start & ~annul;
    assign annulCalc = annul;
`else
    assign startAcc  = start;
    assign annulCalc = 1'b0;
    logic unusedAnnul;
    assign unusedAnnul = annul;
`endif

    // One restoring step: the compare is WIDTH+1 bits so a full-scale divisor cannot overflow.
    assign shifted = {remR, dvd[WIDTH-1]};
    assign ge      = shifted >= {1'b0, dvs};
    assign stepRem = ge ? WIDTH'(shifted - {1'b0, dvs}) : shifted[WIDTH-1:0];
    assign stepQ   = {dvd[WIDTH-2:0], ge};
    assign absA    = (signed_div && opa[WIDTH-1]) ? WIDTH'(-opa) : opa;
    assign absB    = (signed_div && opb[WIDTH-1]) ? WIDTH'(-opb) : opb;

    // Next-state, datapath and output logic.
    always_comb begin
        stateNext     = state;
        cntNext       = cnt;
        remNext       = remR;
        dvdNext       = dvd;
        dvsNext       = dvs;
        negQNext      = negQ;
        negRNext      = negR;
        busyNext      = 1'b0;
        readyNext     = 1'b0;
        dbzNext       = dbz;
        quotientNext  = quotient;
        remainderNext = remainder;
        stall         = 1'b0;
        case (state)
            IDLE: begin
                if (startAcc) begin
                    stall = 1'b1;
                    if (opb == '0) begin
                        stateNext     = DONE;
                        readyNext     = 1'b1;
                        dbzNext       = 1'b1;
                        quotientNext  = '1;
                        remainderNext = opa;
                    end else begin
                        stateNext = CALC;
                        busyNext  = 1'b1;
                        dvdNext   = absA;
                        dvsNext   = absB;
                        remNext   = '0;
                        cntNext   = '0;
                        negQNext  = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                        negRNext  = signed_div & opa[WIDTH-1];
                    end
                end
            end
            CALC: begin
                stall = 1'b1;
                if (annulCalc) begin
                    stateNext = IDLE;
                end else begin
                    remNext = stepRem;
                    dvdNext = stepQ;
                    cntNext = cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        stateNext     = DONE;
                        readyNext     = 1'b1;
                        dbzNext       = 1'b0;
                        quotientNext  = negQ ? WIDTH'(-stepQ) : stepQ;
                        remainderNext = negR ? WIDTH'(-stepRem) : stepRem;
                    end else begin
                        busyNext = 1'b1;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            remR      <= '0;
            dvd       <= '0;
            dvs       <= '0;
            negQ      <= 1'b0;
            negR      <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            dbz       <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            remR      <= remNext;
            dvd       <= dvdNext;
            dvs       <= dvsNext;
            negQ      <= negQNext;
            negR      <= negRNext;
            busy      <= busyNext;
            ready     <= readyNext;
            dbz       <= dbzNext;
            quotient  <= quotientNext;
            remainder <= remainderNext;
        end
    end
endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: stimulus pushes expected results, a monitor checks each ready pulse.
module tb_div_seq;
    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst, start, signedDiv, annul;
    logic [W-1:0] opa, opb;
    logic         stall, busy, ready, dbz;
    logic [W-1:0] quotient, remainder;

    div_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_div(signedDiv), .annul(annul),
        .opa(opa), .opb(opb), .stall(stall), .busy(busy), .ready(ready),
        .quotient(quotient), .remainder(remainder), .dbz(dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           due;
    } expT;

    expT sbq[$];
    expT e;
    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  stallCnt = 0;
    int  readyCnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst === 1'b0 && ready === 1'b1) begin
            readyCnt++;
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ready actual=1 required=0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("dbz", W'(dbz), W'(e.dbz));
                check("ready_cycle", W'(cyc), W'(e.due));
            end
        end
    end

    always @(negedge clk) begin
        #1;
        if (stall === 1'b1) stallCnt++;
    end

    task automatic issue(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start     = 1'b1;
        signedDiv = sgn;
        opa       = a;
        opb       = b;
        stallCnt  = 0;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < int'(W) + 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            #2;
            if (sbq.size() == 0) break;
        end
        if (sbq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=pending required=done", name);
            sbq.delete();
        end
    endtask

    task automatic runOp(input string name, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic ed);
        int lat;
        lat = (b == '0) ? 1 : int'(W) + 1;
        issue(sgn, a, b);
        sbq.push_back('{eq, er, ed, cyc + lat});
        drain(name);
        check({name, "_stall_cycles"}, W'(stallCnt), W'(lat));
    endtask

    initial begin
        int n;
        int rc;
        rst = 1'b1; start = 1'b0; signedDiv = 1'b0; annul = 1'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", W'(busy), '0);
        check("rst_ready", W'(ready), '0);
        check("rst_quotient", quotient, '0);
        check("rst_remainder", remainder, '0);
        check("rst_dbz", W'(dbz), '0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        runOp("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        runOp("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        runOp("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        runOp("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
        runOp("div_minneg_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        runOp("divu_minneg_max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        runOp("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
        runOp("div_m5_0", 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1);
        runOp("divu_100_7b", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);

        // Annul at the tenth CALC cycle of 50/3.
        issue(1'b0, 32'd50, 32'd3);
        n = cyc;
`ifndef DIV_ANNUL_EN
        sbq.push_back('{32'd16, 32'd2, 1'b0, n + int'(W) + 1});
`endif
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
`ifdef DIV_ANNUL_EN
        #2;
        check("annul_stall", W'(stall), '0);
        check("annul_busy", W'(busy), '0);
        check("annul_quotient", quotient, 32'd14);
        check("annul_remainder", remainder, 32'd2);
        repeat (int'(W) + 5) @(negedge clk);
`else
        drain("annul_ignored");
`endif

        // A start during CALC must not produce a second result.
        rc = readyCnt;
        issue(1'b0, 32'd1000, 32'd10);
        sbq.push_back('{32'd100, 32'd0, 1'b0, cyc + int'(W) + 1});
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        start = 1'b1; opa = 32'd9; opb = 32'd3;
        drain("start_in_calc");
        repeat (5) @(negedge clk);
        check("one_ready_per_start", W'(readyCnt - rc), W'(1));

        // Reset at CALC cycle 5 clears everything.
        issue(1'b1, 32'd200, 32'd9);
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("midrst_stall", W'(stall), '0);
        check("midrst_busy", W'(busy), '0);
        check("midrst_ready", W'(ready), '0);
        check("midrst_quotient", quotient, '0);
        check("midrst_remainder", remainder, '0);
        check("midrst_dbz", W'(dbz), '0);
        repeat (int'(W) + 5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
